execute_muldiv: RTL and testbench

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/execute_muldiv_if.sv | 26 ++
 rtl/execute_divider.sv | 47 ++++
 rtl/execute_muldiv.sv | 150 +++++++++++++++
 tb/tb_execute_muldiv.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M execute-stage multiply/divide unit: funct3 op encoding,
// FSM states, iteration count and operand-signedness helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } muldiv_state_e;

    localparam int unsigned NumIter = 32;

    function automatic logic is_div_op(input muldiv_op_e op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

    function automatic logic is_rem_op(input muldiv_op_e op);
        return op inside {OpRem, OpRemu};
    endfunction

    function automatic logic a_is_signed(input muldiv_op_e op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic b_is_signed(input muldiv_op_e op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/execute_muldiv_if.sv
// Execute-stage request/response bundle between the pipeline and the mul/div unit.
interface execute_muldiv_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REGISTER_WIDTH = 5
);
    logic                      valid_e_i;
    logic [2:0]                muldiv_op_e_i;
    logic [DATA_WIDTH-1:0]     src_a_e_i;
    logic [DATA_WIDTH-1:0]     src_b_e_i;
    logic [REGISTER_WIDTH-1:0] rd_e_i;
    logic                      flush_e_i;
    logic                      busy_o;
    logic                      done_o;
    logic [DATA_WIDTH-1:0]     result_o;
    logic [REGISTER_WIDTH-1:0] rd_o;

    modport master (
        output valid_e_i, muldiv_op_e_i, src_a_e_i, src_b_e_i, rd_e_i, flush_e_i,
        input  busy_o, done_o, result_o, rd_o
    );

    modport slave (
        input  valid_e_i, muldiv_op_e_i, src_a_e_i, src_b_e_i, rd_e_i, flush_e_i,
        output busy_o, done_o, result_o, rd_o
    );
endinterface

// File: rtl/execute_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
// Outputs show the values after the current step so the caller can latch on the last edge.
module execute_divider #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n_i,
    input  logic                  start,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    logic [DATA_WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;
    logic                  borrow;
    logic [DATA_WIDTH-1:0] rem_step, quo_step;
    logic                  unused_bits;

    assign shifted            = {rem_q, quo_q[DATA_WIDTH-1]};
    assign {borrow, diff}     = {1'b0, shifted} - {2'b00, dsr_q};
    assign rem_step           = borrow ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    assign quo_step           = {quo_q[DATA_WIDTH-2:0], ~borrow};
    // A non-borrowing trial is always below the divisor, so its top bit is zero.
    assign unused_bits        = diff[DATA_WIDTH] ^ shifted[DATA_WIDTH];

    assign quotient  = quo_step;
    assign remainder = rem_step;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (step) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// RV32M multiply/divide unit for the execute stage: shift-add multiplier in this module,
// restoring divider in execute_divider, sign fix-up and result latch on entry to DONE.
module execute_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REGISTER_WIDTH = 5
) (
    input logic             clk,
    input logic             rst_n_i,
    execute_muldiv_if.slave bus
);
    localparam int unsigned CntW = $clog2(NumIter);
    localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    muldiv_state_e             state_q;
    muldiv_op_e                op_q;
    logic [CntW-1:0]           cnt_q;
    logic [REGISTER_WIDTH-1:0] rd_q;
    logic                      neg_res_q, neg_rem_q;
    logic [DATA_WIDTH-1:0]     a_mag_q;
    logic [2*DATA_WIDTH-1:0]   acc_q;
    logic                      done_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic [REGISTER_WIDTH-1:0] rd_out_q;

    muldiv_op_e            op;
    logic [DATA_WIDTH-1:0] a, b, a_mag, b_mag;
    logic                  a_sgn, b_sgn;
    logic                  accept, div_ovf, special;
    logic [DATA_WIDTH-1:0] special_res;

    assign op     = muldiv_op_e'(bus.muldiv_op_e_i);
    assign a      = bus.src_a_e_i;
    assign b      = bus.src_b_e_i;
    assign a_sgn  = a_is_signed(op) & a[DATA_WIDTH-1];
    assign b_sgn  = b_is_signed(op) & b[DATA_WIDTH-1];
    assign a_mag  = a_sgn ? -a : a;
    assign b_mag  = b_sgn ? -b : b;
    assign accept = (state_q == StIdle) && bus.valid_e_i && !bus.flush_e_i;

    assign div_ovf = (op == OpDiv || op == OpRem) && (a == MinNeg) && (b == '1);
    assign special = is_div_op(op) && ((b == '0) || div_ovf);

    always_comb begin
        special_res = '0;
        if (b == '0) begin
            special_res = is_rem_op(op) ? a : '1;
        end else begin
            special_res = is_rem_op(op) ? '0 : MinNeg;
        end
    end

    // Multiplier step: add multiplicand into the upper half when the current bit is set,
    // then shift the whole accumulator (with carry) right by one.
    logic [DATA_WIDTH:0]     mul_sum;
    logic [2*DATA_WIDTH-1:0] acc_step, prod_fix;
    logic [DATA_WIDTH-1:0]   mul_res;

    assign mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                      + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    assign acc_step = {mul_sum, acc_q[DATA_WIDTH-1:1]};
    assign prod_fix = neg_res_q ? -acc_step : acc_step;
    assign mul_res  = (op_q == OpMul) ? prod_fix[DATA_WIDTH-1:0]
                                      : prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];

    logic [DATA_WIDTH-1:0] quo, rem, div_res;

    execute_divider #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_divider (
        .clk       (clk),
        .rst_n_i   (rst_n_i),
        .start     (accept && is_div_op(op) && !special),
        .step      (state_q == StDiv),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    assign div_res = is_rem_op(op_q) ? (neg_rem_q ? -rem : rem)
                                     : (neg_res_q ? -quo : quo);

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            op_q      <= OpMul;
            cnt_q     <= '0;
            rd_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_mag_q   <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q      <= op;
                        rd_q      <= bus.rd_e_i;
                        neg_res_q <= a_sgn ^ b_sgn;
                        neg_rem_q <= a_sgn;
                        a_mag_q   <= a_mag;
                        acc_q     <= {{DATA_WIDTH{1'b0}}, b_mag};
                        cnt_q     <= CntW'(NumIter - 1);
                        if (special) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= special_res;
                            rd_out_q <= bus.rd_e_i;
                        end else begin
                            state_q <= is_div_op(op) ? StDiv : StMul;
                        end
                    end
                end
                StMul, StDiv: begin
                    if (bus.flush_e_i) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        if (state_q == StMul) begin
                            acc_q <= acc_step;
                        end
                        if (cnt_q == '0) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= (state_q == StMul) ? mul_res : div_res;
                            rd_out_q <= rd_q;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy_o   = (state_q == StMul) || (state_q == StDiv)
                          || ((state_q == StIdle) && bus.valid_e_i);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_out_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: directed RV32M corner cases plus random ops
// against a plain-arithmetic reference, with flush, reset and DONE-state behaviour.
module tb_execute_muldiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    execute_muldiv_if #(.DATA_WIDTH(32), .REGISTER_WIDTH(5)) bus ();

    execute_muldiv #(
        .DATA_WIDTH     (32),
        .REGISTER_WIDTH (5)
    ) dut (
        .clk     (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] MinNeg = 32'h8000_0000;

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic signed [31:0] q;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MinNeg && b == 32'hFFFF_FFFF) return MinNeg;
                q = $signed(a) / $signed(b);
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MinNeg && b == 32'hFFFF_FFFF) return 32'd0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MinNeg && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op, wait (bounded) for done_o, report what was seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit noise,
                          output logic [31:0] res, output logic [4:0] rdo, output int lat,
                          output bit busy_ok, output bit pulse_ok);
        @(negedge clk);
        bus.valid_e_i     = 1'b1;
        bus.muldiv_op_e_i = op;
        bus.src_a_e_i     = a;
        bus.src_b_e_i     = b;
        bus.rd_e_i        = rd;
        bus.flush_e_i     = 1'b0;
        #1;
        busy_ok = (bus.busy_o === 1'b1);
        @(posedge clk);
        #1;
        bus.valid_e_i = 1'b0;
        lat = 1;
        while (bus.done_o !== 1'b1 && lat < 100) begin
            if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
            if (noise) begin
                bus.valid_e_i     = 1'($urandom_range(0, 1));
                bus.muldiv_op_e_i = 3'($urandom_range(0, 7));
                bus.src_a_e_i     = $urandom;
                bus.src_b_e_i     = $urandom;
                bus.rd_e_i        = 5'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.valid_e_i = 1'b0;
        res = bus.result_o;
        rdo = bus.rd_o;
        @(posedge clk);
        #1;
        pulse_ok = (bus.done_o === 1'b0) && (bus.result_o === res) && (bus.rd_o === rdo);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.done_o !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b exp 0", bus.done_o);
        end
        checks++;
        if (bus.result_o !== 32'd0) begin
            errors++; $display("FAIL reset_result got %h exp 00000000", bus.result_o);
        end
        checks++;
        if (bus.rd_o !== 5'd0) begin
            errors++; $display("FAIL reset_rd got %0d exp 0", bus.rd_o);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy_idle got %b exp 0", bus.busy_o);
        end
        bus.valid_e_i = 1'b1;
        #1;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++; $display("FAIL reset_busy_valid got %b exp 1", bus.busy_o);
        end
        bus.valid_e_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        v[$];
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          busy_ok, pulse_ok;
        v.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        v.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        v.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
        v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
        v.push_back('{3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1});
        v.push_back('{3'd7, 32'd100, 32'd0, 32'd100, 1});
        v.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, 5'(i + 1), 1'b0, res, rdo, lat, busy_ok, pulse_ok);
            checks++;
            if (res !== v[i].exp) begin
                errors++; $display("FAIL dir%0d_result got %h exp %h", i, res, v[i].exp);
            end
            checks++;
            if (lat != v[i].lat) begin
                errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, v[i].lat);
            end
            checks++;
            if (rdo !== 5'(i + 1)) begin
                errors++; $display("FAIL dir%0d_rd got %0d exp %0d", i, rdo, i + 1);
            end
            checks++;
            if (!busy_ok || !pulse_ok) begin
                errors++;
                $display("FAIL dir%0d_busy_pulse got busy_ok=%0d pulse_ok=%0d exp 1 1",
                         i, busy_ok, pulse_ok);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        logic [4:0]  rd, rdo;
        int          lat, mode;
        bit          busy_ok, pulse_ok;
        for (int n = 0; n < 48; n++) begin
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            rd   = 5'($urandom);
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = MinNeg; b = 32'hFFFF_FFFF; end
            else if (mode == 2) b = 32'($urandom_range(1, 20));
            else if (mode == 3) b = -32'($urandom_range(1, 20));
            exp = ref_model(op, a, b);
            run_op(op, a, b, rd, 1'b1, res, rdo, lat, busy_ok, pulse_ok);
            checks++;
            if (res !== exp || rdo !== rd) begin
                errors++;
                $display("FAIL rand%0d op%0d a=%h b=%h got %h/%0d exp %h/%0d",
                         n, op, a, b, res, rdo, exp, rd);
            end
            checks++;
            if (lat != ref_latency(op, a, b) || !pulse_ok) begin
                errors++;
                $display("FAIL rand%0d_timing got lat=%0d pulse_ok=%0d exp lat=%0d pulse_ok=1",
                         n, lat, pulse_ok, ref_latency(op, a, b));
            end
        end
    endtask

    task automatic test_done_blocks();
        @(negedge clk);
        bus.valid_e_i     = 1'b1;
        bus.muldiv_op_e_i = 3'd5;
        bus.src_a_e_i     = 32'd5;
        bus.src_b_e_i     = 32'd0;
        bus.rd_e_i        = 5'd3;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL done_state got done=%b busy=%b exp 1 0", bus.done_o, bus.busy_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL done_no_accept got done=%b busy=%b exp 0 1", bus.done_o, bus.busy_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL done_reaccept got done=%b res=%h exp 1 ffffffff",
                     bus.done_o, bus.result_o);
        end
        bus.valid_e_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        logic [31:0] held, res;
        logic [4:0]  rdo;
        int          lat;
        bit          busy_ok, pulse_ok, saw_done;
        held = bus.result_o;
        @(negedge clk);
        bus.valid_e_i     = 1'b1;
        bus.muldiv_op_e_i = 3'd5;
        bus.src_a_e_i     = 32'd12345;
        bus.src_b_e_i     = 32'd11;
        bus.rd_e_i        = 5'd21;
        @(posedge clk);
        #1;
        bus.valid_e_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.flush_e_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_e_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got busy=%b done=%b exp 0 0", bus.busy_o, bus.done_o);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done_o !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || bus.result_o !== held) begin
            errors++;
            $display("FAIL flush_no_done got saw_done=%0d res=%h exp 0 %h",
                     saw_done, bus.result_o, held);
        end
        run_op(3'd5, 32'd1000, 32'd7, 5'd9, 1'b0, res, rdo, lat, busy_ok, pulse_ok);
        checks++;
        if (res !== 32'd142 || rdo !== 5'd9 || lat != 33) begin
            errors++;
            $display("FAIL flush_next_op got %h/%0d/%0d exp 0000008e/9/33", res, rdo, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          busy_ok, pulse_ok, saw_done;
        @(negedge clk);
        bus.valid_e_i     = 1'b1;
        bus.muldiv_op_e_i = 3'd0;
        bus.src_a_e_i     = 32'd3;
        bus.src_b_e_i     = 32'd5;
        bus.rd_e_i        = 5'd17;
        @(posedge clk);
        #1;
        bus.valid_e_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.done_o !== 1'b0 || bus.result_o !== 32'd0 || bus.rd_o !== 5'd0
            || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got done=%b res=%h rd=%0d busy=%b exp 0 0 0 0",
                     bus.done_o, bus.result_o, bus.rd_o, bus.busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done_o !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL reset_mid_no_done got 1 exp 0");
        end
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 1'b0, res, rdo, lat, busy_ok,
               pulse_ok);
        checks++;
        if (res !== 32'hFFFF_FFFF || rdo !== 5'd30 || lat != 33) begin
            errors++;
            $display("FAIL reset_mid_next_op got %h/%0d/%0d exp ffffffff/30/33", res, rdo, lat);
        end
    endtask

    initial begin
        bus.valid_e_i     = 1'b0;
        bus.muldiv_op_e_i = 3'd0;
        bus.src_a_e_i     = 32'd0;
        bus.src_b_e_i     = 32'd0;
        bus.rd_e_i        = 5'd0;
        bus.flush_e_i     = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_done_blocks();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
